// File: rtl/wb_data_select.sv
// wb_data_select: registered write-back stage. Picks register-file write data
// from NUM_SRC sources, applies load size/sign extension to the DMEM source,
// and tracks committed writes. Stall/flush control the single register stage.
module wb_data_select #(
   parameter int DATA_W   = 32,
   parameter int NUM_SRC  = 4,
   parameter int SEL_W    = 2,
   parameter int LOAD_SRC = 1,
   parameter int CNT_W    = 32
) (
   input  logic                      CLK,
   input  logic                      RST_N,
   input  logic [NUM_SRC*DATA_W-1:0] SrcIn,
   input  logic [SEL_W-1:0]          WRITEDATASELECT,
   input  logic [1:0]                LDSIZE,
   input  logic                      LDSIGNED,
   input  logic [1:0]                AddrLo,
   input  logic [4:0]                WriteRegIn,
   input  logic                      REGWRITE_IN,
   input  logic                      IN_VALID,
   input  logic                      STALL,
   input  logic                      FLUSH,
   output logic [DATA_W-1:0]         WriteDataOut,
   output logic [4:0]                WriteRegOut,
   output logic                      REGWRITE_OUT,
   output logic                      OUT_VALID,
   output logic                      SEL_ERR,
   output logic [CNT_W-1:0]          WbCount
);

   logic [NUM_SRC-1:0][DATA_W-1:0] src;
   logic [31:0]       low;
   logic [31:0]       part;
   logic [DATA_W-1:0] part_w;
   logic [DATA_W-1:0] ext;
   logic [DATA_W-1:0] sel_data;
   int                width;
   logic              msb;
   logic              fill;
   logic              sel_ok;
   logic              commit;

   assign src    = SrcIn;
   assign low    = src[LOAD_SRC][31:0];
   assign commit = IN_VALID & REGWRITE_IN & (WriteRegIn != 5'd0);
   assign sel_ok = int'(WRITEDATASELECT) < NUM_SRC;

   // Load extraction: pick the half/byte lane, then extend to DATA_W.
   // Reserved size 11 falls through to the word path.
   always_comb begin
      part  = low;
      width = 32;
      msb   = low[31];
      case (LDSIZE)
         2'b01: begin
            part  = {16'b0, (AddrLo[1] ? low[31:16] : low[15:0])};
            width = 16;
            msb   = part[15];
         end
         2'b10: begin
            case (AddrLo)
               2'd0:    part = {24'b0, low[7:0]};
               2'd1:    part = {24'b0, low[15:8]};
               2'd2:    part = {24'b0, low[23:16]};
               default: part = {24'b0, low[31:24]};
            endcase
            width = 8;
            msb   = part[7];
         end
         default: ;
      endcase
      fill   = LDSIGNED & msb;
      part_w = DATA_W'(part);
      ext    = '0;
      for (int i = 0; i < DATA_W; i++)
         ext[i] = (i < width) ? part_w[i] : fill;
   end

   // Source mux; an undefined select yields zero rather than stale data.
   always_comb begin
      sel_data = '0;
      for (int i = 0; i < NUM_SRC; i++)
         if (int'(WRITEDATASELECT) == i)
            sel_data = (i == LOAD_SRC) ? ext : src[i];
   end

   // WB register stage: reset > flush > stall > capture.
   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         WriteDataOut <= '0;
         WriteRegOut  <= '0;
         REGWRITE_OUT <= 1'b0;
         OUT_VALID    <= 1'b0;
         SEL_ERR      <= 1'b0;
         WbCount      <= '0;
      end else if (FLUSH) begin
         OUT_VALID    <= 1'b0;
         REGWRITE_OUT <= 1'b0;
      end else if (!STALL) begin
         OUT_VALID    <= IN_VALID;
         REGWRITE_OUT <= commit;
         WriteRegOut  <= WriteRegIn;
         WriteDataOut <= sel_data;
         if (commit)
            WbCount <= WbCount + CNT_W'(1);
         if (IN_VALID && !sel_ok)
            SEL_ERR <= 1'b1;
      end
   end

endmodule

// File: tb/tb_wb_data_select.sv
// Scoreboard bench for wb_data_select (3 sources, 4-bit counter).
module tb_wb_data_select;
   localparam int DW = 32;
   localparam int NS = 3;
   localparam int CW = 4;

   logic          CLK = 1'b0;
   logic          RST_N;
   logic [31:0]   src0, src1, src2;
   logic [1:0]    sel, ldsize, addr_lo;
   logic          ldsigned, regwrite_in, in_valid, stall, flush;
   logic [4:0]    reg_in;
   logic [DW-1:0] wdata;
   logic [4:0]    wreg;
   logic          regwrite_out, out_valid, sel_err;
   logic [CW-1:0] wb_count;

   typedef struct packed {
      logic [31:0]   data;
      logic [4:0]    rd;
      logic          rw;
      logic          vld;
      logic          err;
      logic [CW-1:0] cnt;
   } exp_t;

   exp_t m;
   exp_t sb[$];
   int checks = 0;
   int failures = 0;

   wb_data_select #(.DATA_W(DW), .NUM_SRC(NS), .SEL_W(2), .LOAD_SRC(1), .CNT_W(CW)) dut (
      .CLK(CLK), .RST_N(RST_N), .SrcIn({src2, src1, src0}),
      .WRITEDATASELECT(sel), .LDSIZE(ldsize), .LDSIGNED(ldsigned), .AddrLo(addr_lo),
      .WriteRegIn(reg_in), .REGWRITE_IN(regwrite_in), .IN_VALID(in_valid),
      .STALL(stall), .FLUSH(flush), .WriteDataOut(wdata), .WriteRegOut(wreg),
      .REGWRITE_OUT(regwrite_out), .OUT_VALID(out_valid), .SEL_ERR(sel_err), .WbCount(wb_count)
   );

   always #5 CLK = ~CLK;

   // Watchdog so the run can never hang.
   initial begin
      #200000;
      $display("FAIL watchdog: timeout reached, expected finish");
      $fatal(1);
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Reference load extension written with shifts, independent of the RTL structure.
   function automatic logic [31:0] m_load(input logic [31:0] d, input logic [1:0] sz,
                                          input logic sg, input logic [1:0] off);
      logic [31:0] b;
      logic [31:0] h;
      case (sz)
         2'b10: begin
            b = (d >> (8 * off)) & 32'hFF;
            return (sg && b[7]) ? (b | 32'hFFFF_FF00) : b;
         end
         2'b01: begin
            h = off[1] ? (d >> 16) : (d & 32'hFFFF);
            return (sg && h[15]) ? (h | 32'hFFFF_0000) : h;
         end
         default: return d;
      endcase
   endfunction

   // Drive one cycle of stimulus, advance the model, push expected, compare after the edge.
   task automatic step(input logic rst, input logic [1:0] s, input logic [1:0] sz,
                       input logic sg, input logic [1:0] off, input logic [4:0] rd,
                       input logic rw, input logic v, input logic st, input logic fl);
      logic [31:0] d;
      logic        cm;
      exp_t        e;
      @(negedge CLK);
      RST_N = rst; sel = s; ldsize = sz; ldsigned = sg; addr_lo = off;
      reg_in = rd; regwrite_in = rw; in_valid = v; stall = st; flush = fl;
      case (s)
         2'd0:    d = src0;
         2'd1:    d = m_load(src1, sz, sg, off);
         2'd2:    d = src2;
         default: d = 32'h0;
      endcase
      cm = v && rw && (rd != 5'd0);
      if (!rst) m = '0;
      else if (fl) begin m.vld = 1'b0; m.rw = 1'b0; end
      else if (!st) begin
         m.vld = v; m.rw = cm; m.rd = rd; m.data = d;
         if (cm) m.cnt = m.cnt + 1'b1;
         if (v && s == 2'd3) m.err = 1'b1;
      end
      sb.push_back(m);
      @(posedge CLK);
      #1;
      e = sb.pop_front();
      chk("data",  64'(wdata),        64'(e.data));
      chk("reg",   64'(wreg),         64'(e.rd));
      chk("rw",    64'(regwrite_out), 64'(e.rw));
      chk("vld",   64'(out_valid),    64'(e.vld));
      chk("err",   64'(sel_err),      64'(e.err));
      chk("cnt",   64'(wb_count),     64'(e.cnt));
   endtask

   task automatic rnd_step(input logic rst, input logic st, input logic fl);
      step(rst, 2'($urandom_range(3)), 2'($urandom_range(3)), 1'($urandom_range(1)),
           2'($urandom_range(3)), 5'($urandom_range(31)), 1'($urandom_range(1)),
           1'($urandom_range(1)), st, fl);
   endtask

   logic [1:0]  ld_sz [5] = '{2'b10, 2'b10, 2'b01, 2'b01, 2'b11};
   logic        ld_sg [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
   logic [1:0]  ld_of [5] = '{2'd0, 2'd2, 2'd2, 2'd0, 2'd0};
   logic [31:0] ld_ex [5] = '{32'hFFFF_FFC3, 32'h0000_00F7, 32'hFFFF_80F7,
                              32'h0000_A5C3, 32'h80F7_A5C3};

   initial begin
      m = '0;
      src0 = $urandom; src1 = $urandom; src2 = $urandom;
      // Reset with random inputs
      rnd_step(1'b0, 1'b0, 1'b0);
      rnd_step(1'b0, 1'b0, 1'b0);
      chk("rst_cnt_lit", 64'(wb_count), 64'd0);

      // Select sweep
      src0 = 32'h1111_1111; src1 = 32'h2222_2222; src2 = 32'h0040_0010;
      for (int i = 0; i < 3; i++)
         step(1'b1, 2'(i), 2'b00, 1'b0, 2'd0, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0);
      chk("sweep_last_lit", 64'(wdata), 64'h0040_0010);
      chk("sweep_cnt_lit", 64'(wb_count), 64'd3);

      // Load extension table
      src1 = 32'h80F7_A5C3;
      for (int i = 0; i < 5; i++) begin
         step(1'b1, 2'd1, ld_sz[i], ld_sg[i], ld_of[i], 5'd7, 1'b1, 1'b1, 1'b0, 1'b0);
         chk("load_lit", 64'(wdata), 64'(ld_ex[i]));
      end

      // Stall 3 cycles with changing inputs, then stall+flush together
      for (int i = 0; i < 3; i++) begin
         src0 = $urandom; src2 = $urandom;
         rnd_step(1'b1, 1'b1, 1'b0);
      end
      rnd_step(1'b1, 1'b1, 1'b1);
      chk("flush_data_lit", 64'(wdata), 64'h80F7_A5C3);

      // r0 suppression, then sticky select error
      step(1'b1, 2'd0, 2'b00, 1'b0, 2'd0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0);
      step(1'b1, 2'd3, 2'b00, 1'b0, 2'd0, 5'd9, 1'b1, 1'b1, 1'b0, 1'b0);
      chk("err_data_lit", 64'(wdata), 64'd0);
      step(1'b1, 2'd0, 2'b00, 1'b0, 2'd0, 5'd9, 1'b1, 1'b1, 1'b0, 1'b0);
      chk("err_sticky_lit", 64'(sel_err), 64'd1);
      step(1'b0, 2'd0, 2'b00, 1'b0, 2'd0, 5'd9, 1'b1, 1'b1, 1'b0, 1'b0);
      step(1'b1, 2'd3, 2'b00, 1'b0, 2'd0, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0);
      chk("err_invalid_lit", 64'(sel_err), 64'd0);

      // Counter wrap: 17 commits from zero lands on 1
      step(1'b0, 2'd0, 2'b00, 1'b0, 2'd0, 5'd1, 1'b0, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 17; i++) begin
         src0 = $urandom; src2 = $urandom;
         step(1'b1, 2'(i % 3), 2'($urandom_range(3)), 1'($urandom_range(1)),
              2'($urandom_range(3)), 5'(1 + (i % 31)), 1'b1, 1'b1, 1'b0, 1'b0);
      end
      chk("wrap_cnt_lit", 64'(wb_count), 64'd1);

      // Random mix, then reset while stalled
      for (int i = 0; i < 20; i++) begin
         src0 = $urandom; src1 = $urandom; src2 = $urandom;
         rnd_step(1'b1, 1'($urandom_range(3) == 0), 1'($urandom_range(5) == 0));
      end
      rnd_step(1'b1, 1'b1, 1'b0);
      rnd_step(1'b0, 1'b1, 1'b0);
      chk("rst_stall_vld_lit", 64'(out_valid), 64'd0);
      chk("rst_stall_data_lit", 64'(wdata), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
